// File: rtl/reg_group_reader.sv
// reg_group_reader
//   Read-side companion to a COUNT x WIDTH register bank. Accepts a read
//   request and returns register contents on a registered valid/ready stream.
//   Two request kinds are supported:
//     - single read : one-hot SEL picks a register. A zero or multi-hot SEL
//                     returns one error word.
//     - scan read   : SCAN=1 returns every register in index order. The final
//                     word carries dout_last.
//   Each word is sampled from R on the edge that loads it into dout. A scan
//   therefore follows register writes that happen while it is running.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   R          live register bank contents, [COUNT-1:0][WIDTH-1:0]
//   SEL        one-hot select for a single read (sampled on accept)
//   SCAN       1 = scan read of all registers (sampled on accept)
//   req_valid  request present
//   req_ready  block can accept a request (registered, high in IDLE)
//   dout       returned register value
//   dout_idx   index of the returned register
//   dout_last  final word of the current response
//   dout_err   select was zero or multi-hot
//   out_valid  output word valid
//   out_ready  consumer accepts the word
module reg_group_reader #(
  parameter int WIDTH = 16,
  parameter int COUNT = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COUNT-1:0][WIDTH-1:0]  R,
  input  logic [COUNT-1:0]             SEL,
  input  logic                         SCAN,
  input  logic                         req_valid,
  output logic                         req_ready,
  output logic [WIDTH-1:0]             dout,
  output logic [((COUNT > 1) ? $clog2(COUNT) : 1)-1:0] dout_idx,
  output logic                         dout_last,
  output logic                         dout_err,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int IDXW = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SINGLE   = 2'd1,
    SCAN_RUN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              vld_nxt;
  logic              rdy_nxt;
  logic [WIDTH-1:0]  dout_nxt;
  logic [IDXW-1:0]   idx_nxt;
  logic              last_nxt;
  logic              err_nxt;
  logic [IDXW-1:0]   scan_idx_inc;

  // True when exactly one select bit is set.
  function automatic logic sel_is_onehot(input logic [COUNT-1:0] s);
    int n;
    n = 0;
    for (int i = 0; i < COUNT; i++) begin
      n += int'(s[i]);
    end
    return (n == 1);
  endfunction

  // Position of the set bit; only meaningful when sel_is_onehot(s).
  function automatic logic [IDXW-1:0] sel_index(input logic [COUNT-1:0] s);
    logic [IDXW-1:0] k;
    k = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (s[i]) begin
        k = IDXW'(i);
      end
    end
    return k;
  endfunction

  // dout_idx doubles as the scan counter. It only increments while below
  // LAST_IDX, so it never wraps.
  assign scan_idx_inc = dout_idx + 1'b1;

  always_comb begin
    state_nxt = state;
    vld_nxt   = out_valid;
    dout_nxt  = dout;
    idx_nxt   = dout_idx;
    last_nxt  = dout_last;
    err_nxt   = dout_err;

    case (state)
      IDLE: begin
        if (req_valid) begin
          vld_nxt = 1'b1;
          if (SCAN) begin
            state_nxt = SCAN_RUN;
            dout_nxt  = R[0];
            idx_nxt   = '0;
            last_nxt  = (COUNT == 1);
            err_nxt   = 1'b0;
          end else if (sel_is_onehot(SEL)) begin
            state_nxt = SINGLE;
            dout_nxt  = R[sel_index(SEL)];
            idx_nxt   = sel_index(SEL);
            last_nxt  = 1'b1;
            err_nxt   = 1'b0;
          end else begin
            state_nxt = SINGLE;
            dout_nxt  = '0;
            idx_nxt   = '0;
            last_nxt  = 1'b1;
            err_nxt   = 1'b1;
          end
        end
      end
      SINGLE: begin
        if (out_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      SCAN_RUN: begin
        if (out_ready) begin
          if (dout_idx == LAST_IDX) begin
            vld_nxt   = 1'b0;
            state_nxt = IDLE;
          end else begin
            dout_nxt  = R[scan_idx_inc];
            idx_nxt   = scan_idx_inc;
            last_nxt  = (scan_idx_inc == LAST_IDX);
          end
        end
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase

    rdy_nxt = (state_nxt == IDLE);
  end

  // Output register stage: every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      dout_idx  <= '0;
      dout_last <= 1'b0;
      dout_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= rdy_nxt;
      out_valid <= vld_nxt;
      dout      <= dout_nxt;
      dout_idx  <= idx_nxt;
      dout_last <= last_nxt;
      dout_err  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg_group_reader.sv
module tb_reg_group_reader;

  localparam int WIDTH = 16;
  localparam int COUNT = 3;
  localparam int IDXW  = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic                        clk;
  logic                        rst;
  logic [COUNT-1:0][WIDTH-1:0] Rb;
  logic [COUNT-1:0]            SEL;
  logic                        SCAN;
  logic                        req_valid;
  logic                        req_ready;
  logic [WIDTH-1:0]            dout;
  logic [IDXW-1:0]             dout_idx;
  logic                        dout_last;
  logic                        dout_err;
  logic                        out_valid;
  logic                        out_ready;

  int checks = 0;
  int errors = 0;

  // Reference model. A response is a list of register indices; the head is
  // presented and the rest wait in pend. Each word reads the bank at load.
  int              pend[$];
  logic            m_vld, m_ready, m_last, m_err;
  logic [WIDTH-1:0] m_dout;
  logic [IDXW-1:0] m_idx;

  reg_group_reader #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .R(Rb), .SEL(SEL), .SCAN(SCAN),
    .req_valid(req_valid), .req_ready(req_ready),
    .dout(dout), .dout_idx(dout_idx), .dout_last(dout_last),
    .dout_err(dout_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic present(input int i);
    m_dout = Rb[i];
    m_idx  = IDXW'(i);
    m_err  = 1'b0;
    m_last = (pend.size() == 0);
  endtask

  // Apply the rules to the inputs seen at the coming edge.
  task automatic model_edge();
    int k;
    if (rst) begin
      m_vld = 0; m_dout = '0; m_idx = '0; m_last = 0; m_err = 0;
      pend.delete();
    end else if (!m_vld) begin
      if (req_valid) begin
        m_vld = 1;
        pend.delete();
        if (SCAN) begin
          for (int i = 1; i < COUNT; i++) pend.push_back(i);
          present(0);
        end else if ($countones(SEL) == 1) begin
          k = 0;
          for (int i = 0; i < COUNT; i++) if (SEL[i]) k = i;
          present(k);
        end else begin
          m_dout = '0; m_idx = '0; m_last = 1; m_err = 1;
        end
      end
    end else if (out_ready) begin
      if (pend.size() == 0) m_vld = 0;
      else present(pend.pop_front());
    end
    m_ready = !m_vld;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("req_ready", 32'(req_ready), 32'(m_ready));
    check("out_valid", 32'(out_valid), 32'(m_vld));
    check("dout",      32'(dout),      32'(m_dout));
    check("dout_idx",  32'(dout_idx),  32'(m_idx));
    check("dout_last", 32'(dout_last), 32'(m_last));
    check("dout_err",  32'(dout_err),  32'(m_err));
  endtask

  task automatic bank_default();
    Rb[0] = 16'h1111; Rb[1] = 16'h2222; Rb[2] = 16'h3333;
  endtask

  initial begin
    rst = 1; req_valid = 0; SCAN = 0; SEL = '0; out_ready = 0;
    m_vld = 0; m_ready = 1; m_dout = '0; m_idx = '0; m_last = 0; m_err = 0;
    bank_default();

    // Reset, without and with a pending request
    tick();
    req_valid = 1; SEL = 3'b010;
    tick();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_dout",  32'(dout),      32'd0);
    rst = 0;

    // Single read with backpressure; bank write must not leak through
    SEL = 3'b010; req_valid = 1; out_ready = 0;
    tick();
    req_valid = 0;
    Rb[1] = 16'hBEEF;
    tick(); tick(); tick();
    check("single_hold_dout", 32'(dout), 32'h2222);
    check("single_hold_idx",  32'(dout_idx), 32'd1);
    out_ready = 1;
    tick();
    check("single_done_valid", 32'(out_valid), 32'd0);
    check("single_done_ready", 32'(req_ready), 32'd1);
    bank_default();

    // Invalid selects
    SEL = 3'b000; req_valid = 1;
    tick();
    check("inv0_err", 32'(dout_err), 32'd1);
    req_valid = 0;
    tick();
    SEL = 3'b101; req_valid = 1;
    tick();
    check("inv5_err",  32'(dout_err),  32'd1);
    check("inv5_last", 32'(dout_last), 32'd1);
    req_valid = 0;
    tick();

    // Scan at full rate
    SCAN = 1; req_valid = 1; out_ready = 1;
    tick();
    req_valid = 0;
    check("scan_w0", 32'(dout), 32'h1111);
    tick();
    check("scan_w1", 32'(dout), 32'h2222);
    tick();
    check("scan_w2",    32'(dout),      32'h3333);
    check("scan_last2", 32'(dout_last), 32'd1);
    tick();
    check("scan_end", 32'(out_valid), 32'd0);

    // Live sampling and stalls during a scan
    req_valid = 1; out_ready = 0;
    tick();
    req_valid = 0;
    Rb[2] = 16'h4444;
    tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    tick(); tick();
    check("stall_w1", 32'(dout), 32'h2222);
    out_ready = 1;
    tick();
    check("live_w2", 32'(dout), 32'h4444);
    tick();
    bank_default();

    // Reset mid-scan, then a fresh scan
    req_valid = 1;
    tick();
    req_valid = 0;
    tick();
    rst = 1; out_ready = 0;
    tick();
    check("midrst_valid", 32'(out_valid), 32'd0);
    rst = 0; req_valid = 1;
    tick();
    check("rescan_idx", 32'(dout_idx), 32'd0);
    req_valid = 0; out_ready = 1;
    tick(); tick(); tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      SCAN      = ($urandom_range(0, 2) == 0);
      SEL       = COUNT'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0)
        Rb[$urandom_range(0, COUNT-1)] = WIDTH'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_group_reader.md
Name: reg_group_reader

Overview:
- Read-side companion to the register group: takes read requests against the COUNT×WIDTH register bank and returns register contents over a valid/ready output stream.
- Supports a single read (one-hot select, same encoding as the load-enable vector) and a scan read (all registers in index order, with a last flag).
- Sits between the register bank outputs and any consumer such as a bus bridge, debug port or display path.
- Output is registered, so consumers always see a stable word while it is held.

Parameters:
- WIDTH, 16, bits per register.
- COUNT, 3, number of registers (≥1).
- Derived localparam IDXW = max(1, $clog2(COUNT)); not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- R  input  [COUNT-1:0][WIDTH-1:0]  live register bank contents.
- SEL  input  COUNT  one-hot register select for a single read; sampled on request accept.
- SCAN  input  1  1 = scan read of all registers; sampled on request accept.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- dout  output  WIDTH  returned register value.
- dout_idx  output  IDXW  index of the returned register.
- dout_last  output  1  final word of the current response.
- dout_err  output  1  select was invalid (zero or multi-hot).
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst=1 at a clk edge, in any state, including mid-scan or mid-hold):
  - state=IDLE, req_ready=1, out_valid=0.
  - dout=0, dout_idx=0, dout_last=0, dout_err=0.
  - Any pending response is discarded.
- All outputs are registers; no combinational path from inputs to outputs. req_ready = (state==IDLE).
- States: IDLE, SINGLE, SCAN_RUN.
- IDLE, request accepted when req_valid & req_ready at edge t; out_valid=1 from t+1 in every case below.
  - SCAN=1 (SEL ignored):
    - Loads dout=R[0], dout_idx=0, dout_last=(COUNT==1), dout_err=0.
    - Goes to SCAN_RUN, counter=0.
  - SCAN=0 with SEL exactly one-hot, bit k:
    - Loads dout=R[k], dout_idx=k, dout_last=1, dout_err=0.
    - Goes to SINGLE.
  - SCAN=0 with SEL zero or multi-hot:
    - Loads dout=0, dout_idx=0, dout_last=1, dout_err=1.
    - Goes to SINGLE.
- SINGLE:
  - Holds all outputs stable while out_ready=0, even if R changes.
  - On out_valid & out_ready at edge t: out_valid=0 and state=IDLE at t+1.
  - req_ready returns to 1 at t+1, so at most one single read every 2 cycles.
- SCAN_RUN:
  - Holds outputs stable while out_ready=0.
  - On a handshake of word i with i<COUNT-1:
    - Next edge loads R[i+1], dout_idx=i+1, dout_last=(i+1==COUNT-1).
    - out_valid stays 1 (one word per cycle when out_ready is held high).
  - On a handshake of the last word: out_valid=0, state=IDLE.
- Sampling: each word is sampled from R on the edge it is loaded into dout, not at request accept. A scan therefore reflects register writes made during the scan.
- Requests are never accepted while out_valid=1. req_valid may stay asserted and is accepted on the first cycle after return to IDLE.
- The counter never wraps past COUNT-1; dout_idx never exceeds COUNT-1.

Test Plan:
Common setup: WIDTH=16, COUNT=3, R[0]=0x1111, R[1]=0x2222, R[2]=0x3333.
- Reset:
  - Stimulus: rst=1 for 2 cycles, with and without req_valid.
  - Required response: req_ready=1, out_valid=0, dout=0, err=0, last=0 after reset.
- Single read with backpressure:
  - Stimulus: SEL=3'b010, req_valid=1, out_ready=0 for 3 cycles.
  - Required response: dout=0x2222, idx=1, last=1, err=0, stable for 3 cycles even when R[1] is changed to 0xBEEF.
  - After out_ready=1: out_valid=0 next cycle and req_ready=1.
- Invalid select:
  - Stimulus: SEL=3'b000, then SEL=3'b101.
  - Required response: each returns dout=0, err=1, last=1, one response per request.
- Scan at full rate:
  - Stimulus: SCAN=1, out_ready=1.
  - Required response: words 0x1111/0x2222/0x3333 on 3 consecutive cycles, idx 0/1/2, last only on idx 2, then out_valid=0.
- Live sampling and stall during scan:
  - Stimulus: write R[2]=0x4444 while word 0 is held with out_ready=0.
  - Required response: third word = 0x4444.
  - Stimulus: deassert out_ready during word 1.
  - Required response: word 1 held and no word skipped.
- Reset mid-scan:
  - Stimulus: rst during word 1, then a new SCAN request.
  - Required response: out_valid=0 the cycle after reset; the new scan restarts at idx 0.
